// File: rtl/lcd_pkg.sv
// Shared types and opcodes for the HD44780-style 4-bit bus receiver.
package lcd_pkg;

  // Receiver phase: 8-bit power-on mode, waiting for high nibble, high nibble held
  typedef enum logic [1:0] {
    MODE8 = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } lcd_state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_SETDD = 8'h80;
  localparam logic [3:0] FUNC_4BIT = 4'h2;

  // Return-home ignores bit 0, so both 0x02 and 0x03 qualify
  function automatic logic is_home(input logic [7:0] cmd);
    return cmd[7:1] == CMD_HOME[7:1];
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchroniser for the eight LCD bus lines plus the qualified e falling-edge detector.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus,       // {sf_e, e, rs, rw, d, c, b, a}
  output logic       rs_sync,
  output logic       rw_sync,
  output logic [3:0] nib_sync,
  output logic       fall        // synced e went 1->0 while synced sf_e=1
);

  logic [7:0] chain [SYNC_STAGES+1];
  logic [7:0] synced;
  logic       e_prev_reg;

  assign chain[0] = bus;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic [7:0] q_reg;
      // One synchroniser rank for all eight lines
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q_reg <= '0;
        else     q_reg <= chain[gi];
      end
      assign chain[gi+1] = q_reg;
    end
  endgenerate

  assign synced = chain[SYNC_STAGES];

  // Remember the previous synced e level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_prev_reg <= 1'b0;
    else     e_prev_reg <= synced[6];
  end

  assign fall     = e_prev_reg & ~synced[6] & synced[7];
  assign rs_sync  = synced[5];
  assign rw_sync  = synced[4];
  assign nib_sync = synced[3:0];

endmodule

// File: rtl/lcd_nibble_rx.sv
// Receiving end of the 4-bit character-LCD bus: mode switch, nibble assembly,
// DDRAM address tracking, busy model and busy/address read-back.
module lcd_nibble_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int AW           = 7,
  parameter int BUSY_CYC     = 2000,
  parameter int CLR_BUSY_CYC = 80000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sf_e,
  input  logic          e,
  input  logic          rs,
  input  logic          rw,
  input  logic          d,
  input  logic          c,
  input  logic          b,
  input  logic          a,
  output logic          byte_valid,
  output logic          byte_rs,
  output logic [7:0]    byte_data,
  output logic          mode4,
  output logic          busy,
  output logic [AW-1:0] ddram_addr,
  output logic [3:0]    rd_nibble,
  output logic          err_pulse
);
  import lcd_pkg::*;

  localparam int CNT_MAX = (CLR_BUSY_CYC > BUSY_CYC) ? CLR_BUSY_CYC : BUSY_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYC);
  localparam logic [CW-1:0] CLR_LOAD  = CW'(CLR_BUSY_CYC);

  logic          s_rs, s_rw, fall;
  logic [3:0]    s_nib;

  lcd_state_t    state_reg, state_next;
  logic [3:0]    hi_nib_reg, hi_nib_next;
  logic          hi_rs_reg, hi_rs_next;
  logic          hi_rw_reg, hi_rw_next;
  logic          mode4_reg, mode4_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          valid_reg, brs_reg, err_reg, err_next;
  logic [7:0]    bdata_reg;
  logic          wr_fire, wr_rs;
  logic [7:0]    wr_byte;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .bus      ({sf_e, e, rs, rw, d, c, b, a}),
    .rs_sync  (s_rs),
    .rw_sync  (s_rw),
    .nib_sync (s_nib),
    .fall     (fall)
  );

  assign busy       = (cnt_reg != '0);
  assign mode4      = mode4_reg;
  assign ddram_addr = addr_reg;
  assign byte_valid = valid_reg;
  assign byte_rs    = brs_reg;
  assign byte_data  = bdata_reg;
  assign err_pulse  = err_reg;

  // Register all receiver state and the registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= MODE8;
      hi_nib_reg <= 4'h0;
      hi_rs_reg  <= 1'b0;
      hi_rw_reg  <= 1'b0;
      mode4_reg  <= 1'b0;
      addr_reg   <= '0;
      cnt_reg    <= '0;
      valid_reg  <= 1'b0;
      brs_reg    <= 1'b0;
      bdata_reg  <= 8'h00;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hi_nib_reg <= hi_nib_next;
      hi_rs_reg  <= hi_rs_next;
      hi_rw_reg  <= hi_rw_next;
      mode4_reg  <= mode4_next;
      addr_reg   <= addr_next;
      cnt_reg    <= cnt_next;
      valid_reg  <= wr_fire;
      err_reg    <= err_next;
      if (wr_fire) begin
        brs_reg   <= wr_rs;
        bdata_reg <= wr_byte;
      end
    end
  end

  // Nibble FSM: decide whether a complete write byte is produced on this strobe
  always_comb begin
    state_next  = state_reg;
    hi_nib_next = hi_nib_reg;
    hi_rs_next  = hi_rs_reg;
    hi_rw_next  = hi_rw_reg;
    mode4_next  = mode4_reg;
    wr_fire     = 1'b0;
    wr_byte     = 8'h00;
    wr_rs       = 1'b0;
    err_next    = 1'b0;
    if (fall) begin
      case (state_reg)
        MODE8: begin
          // Reads in 8-bit mode carry nothing the model answers
          if (!s_rw) begin
            wr_fire = 1'b1;
            wr_byte = {s_nib, 4'h0};
            wr_rs   = s_rs;
            if (!s_rs && s_nib == FUNC_4BIT) begin
              mode4_next = 1'b1;
              state_next = HI;
            end
          end
        end
        HI: begin
          hi_nib_next = s_nib;
          hi_rs_next  = s_rs;
          hi_rw_next  = s_rw;
          state_next  = LO;
        end
        LO: begin
          state_next = HI;
          if (s_rs != hi_rs_reg || s_rw != hi_rw_reg) begin
            err_next = 1'b1;
          end else if (!s_rw) begin
            wr_fire = 1'b1;
            wr_byte = {hi_nib_reg, s_nib};
            wr_rs   = s_rs;
          end
        end
        default: state_next = MODE8;
      endcase
    end
    if (wr_fire && busy) err_next = 1'b1;
  end

  // Byte decode: address counter update and busy counter reload/countdown
  always_comb begin
    addr_next = addr_reg;
    cnt_next  = busy ? cnt_reg - CW'(1) : cnt_reg;
    if (wr_fire) begin
      cnt_next = BUSY_LOAD;
      if (wr_rs) begin
        addr_next = addr_reg + AW'(1);
      end else if (wr_byte == CMD_CLEAR || is_home(wr_byte)) begin
        addr_next = '0;
        cnt_next  = CLR_LOAD;
      end else if ((wr_byte & CMD_SETDD) != 8'h00) begin
        addr_next = AW'(wr_byte[6:0]);
      end
    end
  end

  // Read-back nibble: busy flag plus address high bits, then address low bits
  always_comb begin
    rd_nibble = 4'h0;
    case (state_reg)
      HI:      rd_nibble = {busy, addr_reg[AW-1:AW-3]};
      LO:      rd_nibble = addr_reg[3:0];
      default: rd_nibble = 4'h0;
    endcase
  end

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Bench for lcd_nibble_rx: directed table, hand-written corner sequences and
// randomized strobes checked against a transaction-level LCD model.
module tb_lcd_nibble_rx;
  localparam int SYNC = 2;
  localparam int AW   = 7;
  localparam int BCYC = 20;
  localparam int CCYC = 200;
  localparam int H    = 5;   // cycles per strobe phase

  logic clk = 0, rst = 0, sf_e = 0, e = 0, rs = 0, rw = 0, d = 0, c = 0, b = 0, a = 0;
  logic byte_valid, byte_rs, mode4, busy, err_pulse;
  logic [7:0] byte_data;
  logic [AW-1:0] ddram_addr;
  logic [3:0] rd_nibble;

  int cyc = 0, checks = 0, passed = 0, txn = 0;

  lcd_nibble_rx #(.SYNC_STAGES(SYNC), .AW(AW), .BUSY_CYC(BCYC), .CLR_BUSY_CYC(CCYC)) dut (
    .clk(clk), .rst(rst), .sf_e(sf_e), .e(e), .rs(rs), .rw(rw),
    .d(d), .c(c), .b(b), .a(a),
    .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
    .mode4(mode4), .busy(busy), .ddram_addr(ddram_addr),
    .rd_nibble(rd_nibble), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: got %0d cycles without finishing, required completion", cyc);
    $fatal(1, "watchdog");
  end

  // Transaction-level model state
  bit m_mode4, m_have_hi, m_hrs, m_hrw;
  logic [3:0] m_hnib;
  int m_addr, m_busy_end;

  // Expectations and observations for the current strobe
  bit e_valid, e_err, e_brs;
  logic [7:0] e_byte;
  int o_nvalid, o_nerr, o_vcyc;
  logic [7:0] o_byte;
  logic o_brs;

  typedef struct {
    bit s, r, w;
    logic [3:0] n;
    bit ev;
    logic [7:0] eb;
    bit er, em4;
    int ea;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    if (byte_valid) begin
      o_nvalid++; o_vcyc = cyc; o_byte = byte_data; o_brs = byte_rs;
    end
    if (err_pulse) o_nerr++;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_mode4 = 0; m_have_hi = 0; m_addr = 0; m_busy_end = 0;
  endtask

  // A complete byte written: p is the cycle the LCD reports it
  task automatic model_write(input logic [7:0] by, input bit r, input int p);
    int dur;
    e_valid = 1; e_byte = by; e_brs = r;
    if (p - 1 < m_busy_end) e_err = 1;
    dur = BCYC;
    if (r) m_addr = (m_addr + 1) % (1 << AW);
    else if (by == 8'h01 || by == 8'h02 || by == 8'h03) begin m_addr = 0; dur = CCYC; end
    else if (by >= 8'h80) m_addr = (by - 8'h80) % (1 << AW);
    m_busy_end = p + dur;
  endtask

  task automatic strobe(input bit s, input bit r, input bit w, input logic [3:0] n, input string tag);
    int t, p, rd_exp;
    bit bz;
    o_nvalid = 0; o_nerr = 0; o_vcyc = -1; o_byte = 0; o_brs = 0;
    sf_e = s; rs = r; rw = w; {d, c, b, a} = n; e = 0;
    repeat (H) tick();
    bz = cyc < m_busy_end;
    if (!m_mode4) rd_exp = 0;
    else if (m_have_hi) rd_exp = m_addr & 15;
    else rd_exp = (bz ? 8 : 0) | ((m_addr >> (AW - 3)) & 7);
    check({tag, ".rd_nibble"}, rd_nibble, rd_exp);
    e = 1;
    repeat (H) tick();
    e = 0;
    t = cyc;
    p = t + SYNC + 1;
    e_valid = 0; e_err = 0; e_byte = 0; e_brs = 0;
    if (s) begin
      if (!m_mode4) begin
        if (!w) begin
          model_write({n, 4'h0}, r, p);
          if (!r && n == 4'h2) begin m_mode4 = 1; m_have_hi = 0; end
        end
      end else if (!m_have_hi) begin
        m_have_hi = 1; m_hnib = n; m_hrs = r; m_hrw = w;
      end else begin
        m_have_hi = 0;
        if (r != m_hrs || w != m_hrw) e_err = 1;
        else if (!w) model_write({m_hnib, n}, r, p);
      end
    end
    repeat (H) tick();
    check({tag, ".valid"}, o_nvalid, e_valid ? 1 : 0);
    if (e_valid) begin
      check({tag, ".byte_data"}, o_byte, e_byte);
      check({tag, ".byte_rs"}, o_brs, e_brs);
      check({tag, ".latency"}, o_vcyc - t, SYNC + 1);
    end
    check({tag, ".err"}, o_nerr, e_err ? 1 : 0);
    check({tag, ".addr"}, ddram_addr, m_addr);
    check({tag, ".mode4"}, mode4, m_mode4);
    check({tag, ".busy"}, busy, (cyc < m_busy_end) ? 1 : 0);
    txn++;
    $display("txn %0d %s sf=%0d rs=%0d rw=%0d nib=%h valid=%0d byte=%h err=%0d addr=%h",
             txn, tag, s, r, w, n, o_nvalid, o_byte, o_nerr, ddram_addr);
  endtask

  initial begin
    tbl = '{
      '{1, 0, 0, 4'h3, 1, 8'h30, 0, 0, 0},
      '{1, 0, 0, 4'h3, 1, 8'h30, 0, 0, 0},
      '{1, 0, 0, 4'h3, 1, 8'h30, 0, 0, 0},
      '{1, 0, 0, 4'h2, 1, 8'h20, 0, 1, 0},
      '{1, 0, 0, 4'h2, 0, 8'h00, 0, 1, 0},
      '{1, 0, 0, 4'h8, 1, 8'h28, 0, 1, 0},
      '{1, 0, 0, 4'h0, 0, 8'h00, 0, 1, 0},
      '{1, 0, 0, 4'h6, 1, 8'h06, 0, 1, 0},
      '{1, 0, 0, 4'h0, 0, 8'h00, 0, 1, 0},
      '{1, 0, 0, 4'hC, 1, 8'h0C, 0, 1, 0},
      '{1, 0, 0, 4'h0, 0, 8'h00, 0, 1, 0},
      '{1, 0, 0, 4'h1, 1, 8'h01, 0, 1, 0},
      '{1, 0, 0, 4'hF, 0, 8'h00, 0, 1, 0},
      '{1, 0, 0, 4'hF, 1, 8'hFF, 0, 1, 'h7F},
      '{1, 1, 0, 4'h3, 0, 8'h00, 0, 1, 'h7F},
      '{1, 1, 0, 4'h2, 1, 8'h32, 1, 1, 0}
    };
    model_reset();

    // Reset state
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.byte_valid", byte_valid, 0);
    check("reset.byte_data", byte_data, 0);
    check("reset.mode4", mode4, 0);
    check("reset.busy", busy, 0);
    check("reset.addr", ddram_addr, 0);
    check("reset.rd_nibble", rd_nibble, 0);
    check("reset.err", err_pulse, 0);
    rst = 0;
    repeat (2) tick();

    // Directed table: 8-bit init, 4-bit commands, clear, address wrap
    for (int i = 0; i < 16; i++) begin
      strobe(tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].n, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.tvalid", i), o_nvalid, tbl[i].ev ? 1 : 0);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d.tbyte", i), o_byte, tbl[i].eb);
        check($sformatf("tbl%0d.trs", i), o_brs, tbl[i].er);
      end
      check($sformatf("tbl%0d.tmode4", i), mode4, tbl[i].em4);
      check($sformatf("tbl%0d.taddr", i), ddram_addr, tbl[i].ea);
      if (i == 11) begin
        // Clear keeps busy for exactly CCYC cycles after its byte_valid
        int vc, guard;
        vc = o_vcyc;
        guard = 0;
        while (busy && guard < CCYC + 50) begin tick(); guard++; end
        check("clear.busy_len", cyc - vc, CCYC);
      end
    end

    // Set address 0x45 and read it back in two strobes
    strobe(1, 0, 0, 4'hC, "c5hi");
    strobe(1, 0, 0, 4'h5, "c5lo");
    check("c5.rd_hi", rd_nibble, 4'hC);
    strobe(1, 0, 1, 4'h0, "rd1");
    check("c5.rd_lo", rd_nibble, 4'h5);
    strobe(1, 0, 1, 4'h0, "rd2");

    // rs mismatch between halves drops the byte; next clean byte decodes
    strobe(1, 1, 0, 4'h4, "mmhi");
    strobe(1, 0, 0, 4'h1, "mmlo");
    check("mismatch.err", o_nerr, 1);
    check("mismatch.novalid", o_nvalid, 0);
    strobe(1, 1, 0, 4'h4, "okhi");
    strobe(1, 1, 0, 4'h1, "oklo");
    check("after_mm.valid", o_nvalid, 1);
    check("after_mm.byte", o_byte, 8'h41);

    // Strobes with sf_e=0 leave the nibble phase untouched
    for (int i = 0; i < 3; i++) strobe(0, 0, 0, 4'h1, "nosel");
    strobe(1, 1, 0, 4'h6, "selhi");
    strobe(1, 1, 0, 4'h1, "sello");
    check("nosel.byte", o_byte, 8'h61);

    // Reset while a high nibble is held clears everything asynchronously
    strobe(1, 1, 0, 4'h7, "prerst");
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rstlo.mode4", mode4, 0);
    check("rstlo.addr", ddram_addr, 0);
    check("rstlo.busy", busy, 0);
    check("rstlo.rd_nibble", rd_nibble, 0);
    check("rstlo.byte_data", byte_data, 0);
    check("rstlo.err", err_pulse, 0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    repeat (2) tick();
    strobe(1, 0, 0, 4'h3, "post_rst");
    check("post_rst.byte", o_byte, 8'h30);
    strobe(1, 0, 0, 4'h2, "post_rst4");

    // Randomized strobes against the model
    for (int i = 0; i < 200; i++) begin
      bit s, r, w;
      logic [3:0] n;
      s = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 1);
      w = ($urandom_range(0, 3) == 0);
      n = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 30)) tick();
      strobe(s, r, w, n, "rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
